// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch queue.
//   - bit positions of the decoded instruction fields (fixed at the top
//     of the instruction word)
//   - default instruction width and halt opcode
//   - fetch state enumeration
package fetch_pkg;

  localparam int OPC_HI  = 24;
  localparam int OPC_LO  = 20;
  localparam int DST_HI  = 19;
  localparam int DST_LO  = 16;
  localparam int SRC1_HI = 15;
  localparam int SRC1_LO = 12;
  localparam int SRC2_HI = 11;
  localparam int SRC2_LO = 8;
  localparam int IMM_HI  = 7;
  localparam int IMM_LO  = 0;

  localparam int         INST_W_DEF  = 25;
  localparam logic [4:0] HALT_OP_DEF = 5'b11111;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO used as the prefetch buffer.
// Ports:
//   clk, Reset  - clock, asynchronous active-high reset
//   push, wdata - write one entry
//   pop         - drop the head entry (ignored when empty)
//   flush       - discard all entries; overrides push and pop
//   rdata       - head entry (meaningful when count != 0)
//   count       - current occupancy, 0..DEPTH
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // The fetch credit rule keeps a free slot for every outstanding read.
      assert (!(push && full));
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage has no reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: instruction fetch unit with prefetch buffer.
// Owns the PC, issues sequential reads to a 1-cycle-latency instruction
// memory and buffers the returned words (with their addresses) in a
// DEPTH-entry FIFO whose head is offered to decode.
// Ports:
//   clk, Reset                  - clock, asynchronous active-high reset
//   fetch_en                    - permit new memory requests
//   mem_req, mem_addr           - memory read request / address
//   mem_rdata                   - read data, one cycle after mem_req
//   redirect_valid, redirect_pc - branch redirect (flushes the queue)
//   out_valid, out_ready        - head instruction handshake
//   out_inst, out_pc            - head instruction word and its address
//   out_opcode .. out_imm       - fields split from out_inst
//   fifo_count                  - buffer occupancy
//   halted                      - fetching stopped by the halt opcode
module inst_fetch_queue
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                INST_W   = INST_W_DEF,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [4:0]        HALT_OP  = HALT_OP_DEF,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              fetch_en,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [INST_W-1:0] mem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic [4:0]        out_opcode,
  output logic [3:0]        out_destin,
  output logic [3:0]        out_src1,
  output logic [3:0]        out_src2,
  output logic [7:0]        out_imm,
  output logic [CW-1:0]     fifo_count,
  output logic              halted
);

  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  fetch_state_t state;
  fetch_state_t state_next;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] resp_pc;
  logic              inflight;
  logic [CW:0]       occupancy;
  logic              issue;
  logic              accept;
  logic              resp_halt;
  logic              pop;
  logic [INST_W+ADDR_W-1:0] head;

  // Credit counts the outstanding read so a response always has a slot;
  // a pop in the same cycle is deliberately not credited.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
  assign issue     = !Reset && (state == RUN) && fetch_en && !redirect_valid
                     && (occupancy < DEPTH_C);

  // After a halt is taken, the read issued alongside it returns while the
  // state is HALTED and is dropped. A response arriving in a redirect
  // cycle is dropped as well; no read is issued then, so nothing else of
  // the old stream can arrive later.
  assign accept    = inflight && (state == RUN) && !redirect_valid;
  assign resp_halt = accept && (mem_rdata[OPC_HI:OPC_LO] == HALT_OP);

  assign out_valid = (fifo_count != '0) && !redirect_valid;
  assign pop       = out_valid && out_ready;

  assign mem_req  = issue;
  assign mem_addr = pc;
  assign halted   = (state == HALTED);

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INST_W + ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .Reset (Reset),
    .push  (accept),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ({mem_rdata, resp_pc}),
    .rdata (head),
    .count (fifo_count)
  );

  assign out_inst   = head[INST_W+ADDR_W-1:ADDR_W];
  assign out_pc     = head[ADDR_W-1:0];
  assign out_opcode = out_inst[OPC_HI:OPC_LO];
  assign out_destin = out_inst[DST_HI:DST_LO];
  assign out_src1   = out_inst[SRC1_HI:SRC1_LO];
  assign out_src2   = out_inst[SRC2_HI:SRC2_LO];
  assign out_imm    = out_inst[IMM_HI:IMM_LO];

  // Redirect wins over everything; a halt rewinds the PC to just past the
  // halt instruction, undoing the increment of a read issued alongside it.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    if (redirect_valid) begin
      state_next = RUN;
      pc_next    = redirect_pc;
    end else begin
      if (issue) pc_next = pc + ADDR_W'(1);
      if (resp_halt) begin
        state_next = HALTED;
        pc_next    = resp_pc + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state    <= RUN;
      pc       <= RESET_PC;
      inflight <= 1'b0;
      resp_pc  <= '0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      inflight <= issue;
      if (issue) resp_pc <= pc;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

  localparam int         ADDR_W = 8;
  localparam int         INST_W = 25;
  localparam int         DEPTH  = 4;
  localparam logic [7:0] RST_PC = 8'h00;
  localparam logic [4:0] HALT   = 5'b11111;
  localparam int         CW     = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              Reset = 1'b1;
  logic              fetch_en = 1'b0;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [INST_W-1:0] mem_rdata = '0;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [INST_W-1:0] out_inst;
  logic [ADDR_W-1:0] out_pc;
  logic [4:0]        out_opcode;
  logic [3:0]        out_destin;
  logic [3:0]        out_src1;
  logic [3:0]        out_src2;
  logic [7:0]        out_imm;
  logic [CW-1:0]     fifo_count;
  logic              halted;

  int errors = 0;
  int checks = 0;

  logic [INST_W-1:0] rom [256];

  // Scoreboard: expected delivery stream (address and word)
  logic [7:0]        sb_pc[$];
  logic [INST_W-1:0] sb_inst[$];

  // Reference model of fetch progress
  logic [7:0] m_q[$];
  logic [7:0] m_pc;
  logic [7:0] m_resp_pc;
  bit         m_inflight;
  bit         m_halted;

  logic [7:0]        mon_pc;
  logic [INST_W-1:0] mon_inst;

  always #5 clk = ~clk;

  inst_fetch_queue #(
    .ADDR_W   (ADDR_W),
    .INST_W   (INST_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RST_PC),
    .HALT_OP  (HALT)
  ) dut (
    .clk            (clk),
    .Reset          (Reset),
    .fetch_en       (fetch_en),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_opcode     (out_opcode),
    .out_destin     (out_destin),
    .out_src1       (out_src1),
    .out_src2       (out_src2),
    .out_imm        (out_imm),
    .fifo_count     (fifo_count),
    .halted         (halted)
  );

  // Instruction ROM with one cycle of read latency
  always @(posedge clk) begin
    if (mem_req) mem_rdata <= rom[mem_addr];
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic bit isHalt(input logic [INST_W-1:0] w);
    logic [INST_W-1:0] t;
    t = w;
    return t[24:20] == HALT;
  endfunction

  // The program stream from a start address runs sequentially (wrapping)
  // up to and including the first halt instruction.
  task automatic loadSegment(input logic [7:0] start);
    logic [7:0] p;
    sb_pc.delete();
    sb_inst.delete();
    p = start;
    for (int k = 0; k < 1024; k++) begin
      sb_pc.push_back(p);
      sb_inst.push_back(rom[p]);
      if (isHalt(rom[p])) break;
      p = p + 8'd1;
    end
  endtask

  // mode 0: keep ROM, 1: ROM[i]=i, 2: random with halt only at 5,
  // 3: random with occasional halts
  task automatic fillRom(input int mode);
    logic [INST_W-1:0] w;
    if (mode == 0) return;
    for (int i = 0; i < 256; i++) begin
      if (mode == 1) begin
        rom[i] = INST_W'(i);
      end else begin
        w = INST_W'($urandom);
        if (isHalt(w)) w[24] = 1'b0;
        if ((mode == 2 && i == 5) || (mode == 3 && $urandom_range(0, 15) == 0))
          w[24:20] = HALT;
        rom[i] = w;
      end
    end
  endtask

  function automatic bit modelReq();
    return !Reset && !m_halted && fetch_en && !redirect_valid
           && (m_q.size() + int'(m_inflight) < DEPTH);
  endfunction

  task automatic modelReset();
    m_q.delete();
    m_pc       = RST_PC;
    m_resp_pc  = '0;
    m_inflight = 0;
    m_halted   = 0;
  endtask

  task automatic stepModel();
    bit req, pop, acc;
    logic [7:0] old_resp;
    req      = modelReq();
    pop      = (m_q.size() != 0) && !redirect_valid && out_ready;
    old_resp = m_resp_pc;
    if (redirect_valid) begin
      m_q.delete();
      m_pc       = redirect_pc;
      m_halted   = 0;
      m_inflight = 0;
    end else begin
      acc = m_inflight && !m_halted;
      if (pop) void'(m_q.pop_front());
      if (acc) m_q.push_back(old_resp);
      if (req) begin
        m_resp_pc = m_pc;
        m_pc      = m_pc + 8'd1;
      end
      m_inflight = req;
      if (acc && isHalt(rom[old_resp])) begin
        m_halted = 1;
        m_pc     = old_resp + 8'd1;
      end
    end
  endtask

  task automatic applyStimulus(input bit fe, input bit rdy, input bit redir,
                               input logic [7:0] tgt);
    Reset          = 1'b0;
    fetch_en       = fe;
    out_ready      = rdy;
    redirect_valid = redir;
    redirect_pc    = tgt;
    if (redir) loadSegment(tgt);
  endtask

  task automatic checkOutput();
    bit req;
    req = modelReq();
    check("mem_req", int'(mem_req), int'(req));
    if (req && mem_req) check("mem_addr", int'(mem_addr), int'(m_pc));
    check("out_valid", int'(out_valid), int'((m_q.size() != 0) && !redirect_valid));
    check("fifo_count", int'(fifo_count), m_q.size());
    check("halted", int'(halted), int'(m_halted));
  endtask

  task automatic runCycle(input bit fe, input bit rdy, input bit redir,
                          input logic [7:0] tgt);
    @(negedge clk);
    applyStimulus(fe, rdy, redir, tgt);
    #1 checkOutput();
    @(posedge clk);
    stepModel();
  endtask

  // Reset is asserted between clock edges with fetch_en high, so the
  // outputs must fall to reset values without waiting for a clock.
  task automatic doReset(input int mode);
    @(negedge clk);
    Reset          = 1'b1;
    fetch_en       = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    fillRom(mode);
    modelReset();
    loadSegment(RST_PC);
    #1 checkOutput();
    @(posedge clk);
  endtask

  // Monitor: every accepted head instruction is checked against the stream
  always @(negedge clk) begin
    #2;
    if (!Reset && out_valid && out_ready) begin
      if (sb_pc.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL delivery at %0t: got pc 0x%0h, expected no instruction",
                 $time, out_pc);
      end else begin
        mon_pc   = sb_pc.pop_front();
        mon_inst = sb_inst.pop_front();
        check("out_pc", int'(out_pc), int'(mon_pc));
        check("out_inst", int'(out_inst), int'(mon_inst));
        check("out_opcode", int'(out_opcode), int'(mon_inst[24:20]));
        check("out_destin", int'(out_destin), int'(mon_inst[19:16]));
        check("out_src1", int'(out_src1), int'(mon_inst[15:12]));
        check("out_src2", int'(out_src2), int'(mon_inst[11:8]));
        check("out_imm", int'(out_imm), int'(mon_inst[7:0]));
      end
    end
  end

  initial begin
    $display("[TB] start");

    // Streaming, then back-pressure until the buffer is full, then resume
    doReset(1);
    repeat (12) runCycle(1, 1, 0, 8'h00);
    repeat (8)  runCycle(1, 0, 0, 8'h00);
    repeat (8)  runCycle(1, 1, 0, 8'h00);

    // Redirect with three buffered entries and one read outstanding
    doReset(1);
    repeat (4) runCycle(1, 0, 0, 8'h00);
    runCycle(1, 0, 1, 8'h40);
    repeat (8) runCycle(1, 1, 0, 8'h00);

    // Halt at address 5, restart at 0x10, then wrap across 0xFF
    doReset(2);
    repeat (15) runCycle(1, 1, 0, 8'h00);
    runCycle(1, 1, 1, 8'h10);
    repeat (10) runCycle(1, 1, 0, 8'h00);
    runCycle(1, 1, 1, 8'hFE);
    repeat (8) runCycle(1, 1, 0, 8'h00);

    // Reset with two entries buffered and a read outstanding
    doReset(1);
    repeat (3) runCycle(1, 0, 0, 8'h00);
    doReset(0);
    repeat (6) runCycle(1, 1, 0, 8'h00);

    // fetch_en low: outstanding read lands, buffer drains
    repeat (2) runCycle(1, 0, 0, 8'h00);
    repeat (6) runCycle(0, 1, 0, 8'h00);

    // Random traffic
    doReset(3);
    repeat (3000)
      runCycle($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7,
               $urandom_range(0, 99) < 3, 8'($urandom));

    @(negedge clk);
    #5;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
